less_than_array: RTL and testbench



---
 rtl/less_than_array.sv | 122 ++++++++++++
 tb/tb_less_than_array.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/less_than_array.sv
// N-lane race-logic less-than (inhibit) with an internal gamma-cycle counter.
// Optional arrival timestamps (t_arr/t_vld) are enabled by defining LT_TIMESTAMP_EN.
module less_than_array #(
    parameter int N_LANES           = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int MAX_PULSE_WIDTH   = 8,
    parameter bit LEQ               = 1'b0,
    localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic               aclk,
    input  logic               rst,
    input  logic               grst,
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    output logic [N_LANES-1:0] q,
    output logic               gstart,
    output logic [TW-1:0]      cnt
`ifdef LT_TIMESTAMP_EN
    ,
    output logic [N_LANES*TW-1:0] t_arr,
    output logic [N_LANES-1:0]    t_vld
`endif
);

    localparam int PW = (MAX_PULSE_WIDTH > 1) ? $clog2(MAX_PULSE_WIDTH) : 1;
    localparam logic [PW-1:0] PW_LAST  = PW'(MAX_PULSE_WIDTH - 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PASS, BLOCK, DONE} lane_state_t;

    lane_state_t        state     [N_LANES];
    lane_state_t        state_nxt [N_LANES];
    logic [PW-1:0]      pw_cnt    [N_LANES];
    logic [PW-1:0]      pw_nxt    [N_LANES];
    logic [N_LANES-1:0] a_d, b_d, a_r, b_r;
    logic               boundary;

    assign boundary = grst | (cnt == CNT_LAST);
    assign gstart   = (cnt == '0);
    assign a_r      = a & ~a_d;
    assign b_r      = b & ~b_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!rst) begin
            cnt <= '0;
            a_d <= '0;
            b_d <= '0;
        end else begin
            cnt <= boundary ? '0 : cnt + TW'(1);
            // Delayed levels survive the boundary: a held level is not a fresh arrival.
            a_d <= a;
            b_d <= b;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            state_nxt[i] = state[i];
            pw_nxt[i]    = pw_cnt[i];
            unique case (state[i])
                IDLE: begin
                    if (a_r[i] && !b_d[i] && (!b_r[i] || LEQ)) begin
                        state_nxt[i] = PASS;
                        pw_nxt[i]    = '0;
                    end else if (a_r[i] || b_r[i]) begin
                        state_nxt[i] = BLOCK;
                    end
                end
                PASS: begin
                    if (!a[i] || pw_cnt[i] == PW_LAST) state_nxt[i] = DONE;
                    else                               pw_nxt[i]    = pw_cnt[i] + PW'(1);
                end
                default: ;
            endcase
            if (boundary) state_nxt[i] = IDLE;
        end
    end

    // q is registered directly from the next state so it never glitches on a state decode.
    always_ff @(posedge aclk) begin
        if (!rst) begin
            q <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                state[i]  <= IDLE;
                pw_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                state[i]  <= state_nxt[i];
                pw_cnt[i] <= pw_nxt[i];
                q[i]      <= (state_nxt[i] == PASS);
            end
        end
    end

`ifdef LT_TIMESTAMP_EN
    logic [N_LANES-1:0] enter;

    always_comb begin
        enter = '0;
        for (int i = 0; i < N_LANES; i++)
            enter[i] = (state[i] == IDLE) && (state_nxt[i] == PASS);
    end

    always_ff @(posedge aclk) begin
        if (!rst || boundary) begin
            t_arr <= '0;
            t_vld <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (enter[i]) begin
                    t_vld[i]          <= 1'b1;
                    t_arr[i*TW +: TW] <= cnt;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_less_than_array.sv
// Scoreboard bench for less_than_array: a history-based reference model predicts each
// cycle's outputs for a LEQ=0 and a LEQ=1 instance driven by the same stimulus.
module tb_less_than_array;

    localparam int N  = 4;
    localparam int G  = 16;
    localparam int M  = 8;
    localparam int TW = 4;

    logic          aclk = 1'b0;
    logic          rst, grst;
    logic [N-1:0]  a, b;
    logic [N-1:0]  q0, q1;
    logic          gstart0, gstart1;
    logic [TW-1:0] cnt0, cnt1;
`ifdef LT_TIMESTAMP_EN
    logic [N*TW-1:0] t_arr0, t_arr1;
    logic [N-1:0]    t_vld0, t_vld1;
`endif

    less_than_array #(.N_LANES(N), .GAMMA_CYCLE_WIDTH(G), .MAX_PULSE_WIDTH(M), .LEQ(1'b0)) dut0 (
        .aclk(aclk), .rst(rst), .grst(grst), .a(a), .b(b),
        .q(q0), .gstart(gstart0), .cnt(cnt0)
`ifdef LT_TIMESTAMP_EN
        , .t_arr(t_arr0), .t_vld(t_vld0)
`endif
    );

    less_than_array #(.N_LANES(N), .GAMMA_CYCLE_WIDTH(G), .MAX_PULSE_WIDTH(M), .LEQ(1'b1)) dut1 (
        .aclk(aclk), .rst(rst), .grst(grst), .a(a), .b(b),
        .q(q1), .gstart(gstart1), .cnt(cnt1)
`ifdef LT_TIMESTAMP_EN
        , .t_arr(t_arr1), .t_vld(t_vld1)
`endif
    );

    always #5 aclk = ~aclk;

    // Per-cycle history of everything sampled at each rising edge.
    logic         h_rst  [$];
    logic         h_grst [$];
    logic [N-1:0] h_a    [$];
    logic [N-1:0] h_b    [$];
    int           h_cnt  [$];

    typedef struct {
        int            k;
        logic [N-1:0]  q0;
        logic [N-1:0]  q1;
        logic [TW-1:0] cnt;
        logic          gs;
        logic [N-1:0]  tv;
        logic [N*TW-1:0] ta;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_errors = 0;
    int next_cnt = 0;

    logic         cur_rst  = 1'b0;
    logic         cur_grst = 1'b0;
    logic [N-1:0] cur_a    = '0;
    logic [N-1:0] cur_b    = '0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s after cycle %0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    // Level of a lane input as seen by the edge detector in cycle s (reset clears it).
    function automatic logic prev_level(int s, int lane, bit is_b);
        if (s == 0 || !h_rst[s-1]) return 1'b0;
        return is_b ? h_b[s-1][lane] : h_a[s-1][lane];
    endfunction

    // First cycle of the gamma window that contains cycle k.
    function automatic int window_start(int k);
        for (int j = k - 1; j >= 0; j--)
            if (!h_rst[j] || h_grst[j] || h_cnt[j] == G - 1) return j + 1;
        return 0;
    endfunction

    // Outcome after the edge ending cycle k: the first edge event in the window decides,
    // and a passed pulse lasts while a stays high, at most M cycles.
    function automatic void lane_outcome(input int k, input int lane, input bit leq,
                                         output bit qv, output bit tv, output int ta);
        int w;
        bit ar, br, bd;
        qv = 1'b0; tv = 1'b0; ta = 0;
        if (!h_rst[k] || h_grst[k] || h_cnt[k] == G - 1) return;
        w = window_start(k);
        for (int s = w; s <= k; s++) begin
            bd = prev_level(s, lane, 1'b1);
            ar = h_a[s][lane] && !prev_level(s, lane, 1'b0);
            br = h_b[s][lane] && !bd;
            if (ar || br) begin
                if (ar && !bd && (!br || leq)) begin
                    tv = 1'b1;
                    ta = h_cnt[s];
                    qv = (k - s < M);
                    for (int j = s + 1; j <= k; j++)
                        if (!h_a[j][lane]) qv = 1'b0;
                end
                return;
            end
        end
    endfunction

    task automatic cycle();
        exp_t e;
        int   k, ta;
        bit   qv, tv;
        @(negedge aclk);
        rst  = cur_rst;
        grst = cur_grst;
        a    = cur_a;
        b    = cur_b;
        h_rst.push_back(cur_rst);
        h_grst.push_back(cur_grst);
        h_a.push_back(cur_a);
        h_b.push_back(cur_b);
        h_cnt.push_back(next_cnt);
        k = h_a.size() - 1;
        next_cnt = (!cur_rst || cur_grst) ? 0 : (next_cnt + 1) % G;
        e.k   = k;
        e.cnt = TW'(next_cnt);
        e.gs  = (next_cnt == 0);
        e.q0  = '0; e.q1 = '0; e.tv = '0; e.ta = '0;
        for (int i = 0; i < N; i++) begin
            lane_outcome(k, i, 1'b0, qv, tv, ta);
            e.q0[i] = qv;
            e.tv[i] = tv;
            e.ta[i*TW +: TW] = TW'(ta);
            lane_outcome(k, i, 1'b1, qv, tv, ta);
            e.q1[i] = qv;
        end
        sb.push_back(e);
    endtask

    task automatic wait_cnt(input int t);
        int guard = 0;
        while (next_cnt != t && guard < 4 * G) begin
            cycle();
            guard++;
        end
    endtask

    // Monitor: compares DUT outputs shortly after each edge against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q_leq0",   e.k, 32'(q0),      32'(e.q0));
                check("q_leq1",   e.k, 32'(q1),      32'(e.q1));
                check("cnt_leq0", e.k, 32'(cnt0),    32'(e.cnt));
                check("cnt_leq1", e.k, 32'(cnt1),    32'(e.cnt));
                check("gstart",   e.k, 32'(gstart0), 32'(e.gs));
                check("gstart1",  e.k, 32'(gstart1), 32'(e.gs));
`ifdef LT_TIMESTAMP_EN
                check("t_vld",    e.k, 32'(t_vld0),  32'(e.tv));
                check("t_arr",    e.k, 32'(t_arr0),  32'(e.ta));
`endif
            end
        end
    end

    initial begin
        int drain;
        rst = 1'b0; grst = 1'b0; a = '0; b = '0;

        // Reset with all inputs high, then release holding them.
        cur_rst = 1'b0; cur_a = '1; cur_b = '1;
        repeat (2) cycle();
        cur_rst = 1'b1;
        repeat (4) cycle();
        cur_a = '0; cur_b = '0;
        wait_cnt(0);

        // Lanes 0..3: pass then fall, inhibited, tie, pulse clamp.
        wait_cnt(1);  cur_a[3] = 1'b1; cycle();
        wait_cnt(2);  cur_a[0] = 1'b1; cur_b[1] = 1'b1; cur_a[2] = 1'b1; cur_b[2] = 1'b1; cycle();
        wait_cnt(4);  cur_b[0] = 1'b1; cur_a[1] = 1'b1; cycle();
        wait_cnt(8);  cur_a[0] = 1'b0; cycle();
        wait_cnt(15); cur_a[3] = 1'b0; cycle();
        cur_a = '0; cur_b = '0;
        repeat (2) cycle();

        // Gamma reset mid-pulse, re-arrival, and b held across the boundary.
        wait_cnt(2);  cur_a[0] = 1'b1; cycle();
        wait_cnt(5);  cur_grst = 1'b1; cycle();
        cur_grst = 1'b0;
        wait_cnt(1);  cur_a[0] = 1'b0; cycle();
        wait_cnt(3);  cur_a[0] = 1'b1; cycle();
        wait_cnt(10); cur_a[0] = 1'b0; cur_b[1] = 1'b1; cycle();
        wait_cnt(4);  cur_a[1] = 1'b1; cycle();
        wait_cnt(9);  cur_a = '0; cur_b = '0; cycle();

        // Randomized traffic with occasional gamma and full resets.
        repeat (1200) begin
            cur_rst  = ($urandom_range(0, 199) != 0);
            cur_grst = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) cur_a[i] = ~cur_a[i];
                if ($urandom_range(0, 7) == 0) cur_b[i] = ~cur_b[i];
            end
            cycle();
        end

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge aclk);
            drain++;
        end
        #3;
        if (sb.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d predictions left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
